dmem_byte_arbiter: RTL and testbench
====================================

// Module: dmem_byte_arbiter
// PURPOSE
//  Shares one byte-wide data-memory port between two requesters: port 0 is the CPU MEM stage, port 1 is the DMA/debug loader.
//  Serialises each byte/half/word access into 1/2/4 little-endian byte cycles on the memory port.
//  Round-robin arbitration; one transaction in flight; per-port done pulse returns read data.
// PARAMETERS
//  ADDR_W   32  address width, both requesters and the memory port
//  RR_EN    1   1 = round-robin between ports; 0 = fixed priority, port 0 wins
// PORTS
//  clk_i         in   1       clock, all logic on rising edge
//  rst_i         in   1       synchronous reset, active-high
//  r0_req_i      in   1       port 0 request; held high until r0_done_o
//  r0_we_i       in   1       port 0: 1 = store, 0 = load
//  r0_size_i     in   2       port 0 size: 00 byte, 01 half, 10 word, 11 treated as word
//  r0_addr_i     in   ADDR_W  port 0 byte address; any alignment is legal
//  r0_wdata_i    in   32      port 0 store data; low bytes used for byte/half
//  r0_done_o     out  1       port 0 one-cycle completion pulse
//  r1_*          -    -       port 1 set: same names, widths and meanings as r0_*
//  rdata_o       out  32      load data, zero-extended; valid while rX_done_o is high
//  busy_o        out  1       transaction in progress (any state other than IDLE)
//  grant_o       out  1       owner of the current/last transaction (0/1)
//  mem_en_o      out  1       memory byte access strobe
//  mem_we_o      out  1       memory byte write enable (only meaningful with mem_en_o)
//  mem_addr_o    out  ADDR_W  memory byte address
//  mem_wdata_o   out  8       memory write byte
//  mem_rdata_i   in   8       memory read byte; valid the cycle after en & !we
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; rr pointer favours port 0; latched request cleared.
//  Reset mid-transaction: aborts immediately; no done pulse; partial memory writes stay.
//  FSM states: IDLE, XFER, RD_LAST, DONE.
//  IDLE: if any req is high, select the winner:
//    - RR_EN=1, both ports requesting: the port not granted last wins.
//    - Otherwise the single requester wins.
//    On the same edge: latch we/size/addr/wdata; set nbytes=1<<min(size,2); cnt=0;
//    grant_o=winner; go to XFER. No memory access happens in IDLE.
//  XFER, each cycle:
//    - drive mem_en_o=1, mem_we_o=we, mem_addr_o=addr+cnt (wraps mod 2^ADDR_W),
//      mem_wdata_o=wdata[8*cnt+:8]; then cnt++.
//    - Loads: if cnt>0, capture mem_rdata_i into rdata byte lane cnt-1.
//    - On the last byte (cnt==nbytes-1): store -> DONE; load -> RD_LAST.
//  RD_LAST: mem_en_o=0; capture mem_rdata_i into byte lane nbytes-1; go to DONE.
//  DONE: rX_done_o=1 for the owner only; rdata_o is stable; rr pointer := owner; go to IDLE.
//    - Requester drops req the same cycle it sees done.
//    - A req still high in IDLE on the next cycle starts a new transaction.
//  rdata_o: unused upper bytes are 0. It holds its value after DONE until the next load's first capture.
//  Latency, from the request-accept edge: store n bytes -> done n+1 cycles later;
//    load n bytes -> done n+2 cycles later. Word load = 6, byte store = 2.
//  Request inputs are ignored outside IDLE; changes after the latch have no effect.
//  A done pulse never goes to the non-owning port; mem_en_o is 0 in IDLE and DONE.
//  A requester dropping req mid-transaction is illegal; the transaction still completes.
// STRUCTURE
//  Package dmem_arb_pkg holds:
//    - state encoding: IDLE=2'd0, XFER=2'd1, RD_LAST=2'd2, DONE=2'd3;
//    - size codes: SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
//    - function size_to_nbytes.
//  Sub-module rr_arb2: 2-input round-robin/fixed-priority picker with pointer update (RR_EN passed down).
//  The top level holds the FSM, byte counter, latch registers and rdata assembly.
// TESTING
//  1. r0 word store addr=0x10 data=0xDEADBEEF -> bytes EF,BE,AD,DE written at 0x10..0x13 on 4 consecutive cycles; r0_done_o 5 cycles after accept.
//  2. r1 word load addr=0x10 after test 1 -> rdata_o=0xDEADBEEF with r1_done_o, 6 cycles after accept; r0_done_o stays 0.
//  3. r0 and r1 both request the same cycle, RR_EN=1, last grant=0 -> r1 served first, then r0; grant_o 1 then 0. With RR_EN=0 -> r0 first.
//  4. r0 byte load addr=0x13 (mem=0xDE) -> rdata_o=0x000000DE; half store 0xA5B6 at addr=0x7 (misaligned) -> writes 0x07=B6, 0x08=A5.
//  5. Word store at addr=0xFFFFFFFE -> bytes go to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (wrap).
//  6. rst_i asserted during the 3rd XFER cycle of a word store -> next cycle busy_o=0, mem_en_o=0, no done pulse; a new request afterwards completes normally.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the byte-serialising data-memory arbiter.
// State encoding, size codes and the latched request bundle.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RD_LAST = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef struct packed {
        logic        we;
        logic [1:0]  last_idx;
        logic [31:0] wdata;
    } xact_t;

    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        logic [2:0] nb;
        case (size)
            SZ_B:    nb = 3'd1;
            SZ_H:    nb = 3'd2;
            default: nb = 3'd4;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/dmem_byte_arbiter_rr_arb2.sv
// Two-way picker: round-robin on the last owner, or fixed priority
// to port 0 when RR_EN is clear.
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    input  logic upd_id,
    output logic valid,
    output logic pick
);

    logic last;

    // last resets to 1 so port 0 wins the first contended round
    always_ff @(posedge clk_i) begin
        if (rst_i)
            last <= 1'b1;
        else if (upd)
            last <= upd_id;
    end

    always_comb begin
        valid = req0 | req1;
        pick  = req1;
        if (req0 && req1)
            pick = RR_EN ? ~last : 1'b0;
    end

endmodule

// File: rtl/dmem_byte_arbiter.sv
// Shares a byte-wide memory port between CPU (port 0) and loader (port 1),
// splitting each access into little-endian byte cycles.
module dmem_byte_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              r0_req_i,
    input  logic              r0_we_i,
    input  logic [1:0]        r0_size_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [31:0]       r0_wdata_i,
    output logic              r0_done_o,
    input  logic              r1_req_i,
    input  logic              r1_we_i,
    input  logic [1:0]        r1_size_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [31:0]       r1_wdata_i,
    output logic              r1_done_o,
    output logic [31:0]       rdata_o,
    output logic              busy_o,
    output logic              grant_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    state_e            state;
    xact_t             lat;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        cnt;
    logic              owner;
    logic [31:0]       rdata_q;

    logic              arb_valid;
    logic              arb_pick;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_nb;
    logic              in_xfer;
    logic              last_byte;
    logic [1:0]        cap_lane;
    logic [31:0]       rdata_nx;

    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req0   (r0_req_i),
        .req1   (r1_req_i),
        .upd    (state == DONE),
        .upd_id (owner),
        .valid  (arb_valid),
        .pick   (arb_pick)
    );

    always_comb begin
        sel_we    = arb_pick ? r1_we_i    : r0_we_i;
        sel_size  = arb_pick ? r1_size_i  : r0_size_i;
        sel_addr  = arb_pick ? r1_addr_i  : r0_addr_i;
        sel_wdata = arb_pick ? r1_wdata_i : r0_wdata_i;
        sel_nb    = size_to_nbytes(sel_size);
    end

    assign in_xfer   = (state == XFER);
    assign last_byte = (cnt == lat.last_idx);

    // Read bytes arrive one cycle late; the first capture clears
    // stale upper lanes so narrow loads come back zero-extended.
    always_comb begin
        cap_lane = (state == RD_LAST) ? lat.last_idx : cnt - 2'd1;
        rdata_nx = rdata_q;
        if (cap_lane == 2'd0)
            rdata_nx = '0;
        rdata_nx[{cap_lane, 3'b000} +: 8] = mem_rdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            lat     <= '0;
            addr_q  <= '0;
            cnt     <= '0;
            owner   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        owner        <= arb_pick;
                        lat.we       <= sel_we;
                        lat.last_idx <= 2'(sel_nb - 3'd1);
                        lat.wdata    <= sel_wdata;
                        addr_q       <= sel_addr;
                        cnt          <= '0;
                        state        <= XFER;
                    end
                end
                XFER: begin
                    cnt <= cnt + 2'd1;
                    if (!lat.we && cnt != 2'd0)
                        rdata_q <= rdata_nx;
                    if (last_byte)
                        state <= lat.we ? DONE : RD_LAST;
                end
                RD_LAST: begin
                    rdata_q <= rdata_nx;
                    state   <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = (state != IDLE);
    assign grant_o     = owner;
    assign r0_done_o   = (state == DONE) && !owner;
    assign r1_done_o   = (state == DONE) && owner;
    assign rdata_o     = rdata_q;
    assign mem_en_o    = in_xfer;
    assign mem_we_o    = in_xfer && lat.we;
    assign mem_addr_o  = in_xfer ? addr_q + ADDR_W'(cnt) : '0;
    assign mem_wdata_o = in_xfer ? lat.wdata[{cnt, 3'b000} +: 8] : '0;

endmodule

// File: tb/tb_dmem_byte_arbiter.sv
// Randomised bench for dmem_byte_arbiter against a byte-array memory model.
// Also drives a fixed-priority instance for the contention case.
module tb_dmem_byte_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [1:0]  r0_size, r1_size;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_done, r1_done;
    logic [31:0] rdata;
    logic        busy, grant, mem_en, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic        f_r0_req, f_r1_req;
    logic        f_r0_done, f_r1_done;
    logic [31:0] f_rdata;
    logic        f_busy, f_grant, f_mem_en, f_mem_we;
    logic [31:0] f_mem_addr;
    logic [7:0]  f_mem_wdata;
    logic [7:0]  f_mem_rdata;

    logic [7:0]  phys   [logic [31:0]];
    logic [7:0]  shadow [logic [31:0]];
    logic [39:0] wlog   [$];

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_byte_arbiter #(.ADDR_W(32), .RR_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_size_i(r0_size),
        .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata), .r0_done_o(r0_done),
        .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_size_i(r1_size),
        .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata), .r1_done_o(r1_done),
        .rdata_o(rdata), .busy_o(busy), .grant_o(grant),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    dmem_byte_arbiter #(.ADDR_W(32), .RR_EN(1'b0)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .r0_req_i(f_r0_req), .r0_we_i(1'b1), .r0_size_i(2'b00),
        .r0_addr_i(32'h40), .r0_wdata_i(32'h11), .r0_done_o(f_r0_done),
        .r1_req_i(f_r1_req), .r1_we_i(1'b1), .r1_size_i(2'b00),
        .r1_addr_i(32'h41), .r1_wdata_i(32'h22), .r1_done_o(f_r1_done),
        .rdata_o(f_rdata), .busy_o(f_busy), .grant_o(f_grant),
        .mem_en_o(f_mem_en), .mem_we_o(f_mem_we), .mem_addr_o(f_mem_addr),
        .mem_wdata_o(f_mem_wdata), .mem_rdata_i(f_mem_rdata)
    );

    assign f_mem_rdata = 8'h00;

    function automatic logic [7:0] rd_phys(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rd_sh(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : 8'h00;
    endfunction

    // Byte memory: writes land on the edge, reads return next cycle;
    // idle cycles return noise so a mistimed capture shows up.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            phys[mem_addr] = mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
        if (mem_en && !mem_we)
            mem_rdata <= rd_phys(mem_addr);
        else
            mem_rdata <= 8'($urandom);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit p, input bit v, input bit we,
                           input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d);
        if (!p) begin
            r0_req = v; r0_we = we; r0_size = sz; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = v; r1_we = we; r1_size = sz; r1_addr = a; r1_wdata = d;
        end
    endtask

    task automatic xact(input bit p, input bit we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
        int          n;
        int          lat;
        bit          seen;
        bit          other;
        logic [31:0] exp_rd;
        logic [31:0] got_rd;
        n      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_rd = '0;
        for (int i = 0; i < n; i++)
            exp_rd[8*i +: 8] = rd_sh(a + 32'(i));
        seen   = 1'b0;
        other  = 1'b0;
        lat    = 0;
        got_rd = '0;
        @(posedge clk); #1;
        wlog.delete();
        set_req(p, 1'b1, we, sz, a, d);
        for (int j = 1; j <= 12 && !seen; j++) begin
            @(posedge clk); #1;
            if (p ? r0_done : r1_done)
                other = 1'b1;
            if (p ? r1_done : r0_done) begin
                seen   = 1'b1;
                lat    = j;
                got_rd = rdata;
                chk("grant", grant, p);
                set_req(p, 1'b0, 1'b0, 2'b00, '0, '0);
            end
        end
        set_req(p, 1'b0, 1'b0, 2'b00, '0, '0);
        chk("done_seen", seen, 1'b1);
        chk("other_done", other, 1'b0);
        if (seen)
            chk("latency", lat, we ? n + 1 : n + 2);
        if (we) begin
            chk("wr_count", wlog.size(), n);
            for (int i = 0; i < n && i < wlog.size(); i++)
                chk("wr_byte", wlog[i], {a + 32'(i), d[8*i +: 8]});
            for (int i = 0; i < n; i++)
                shadow[a + 32'(i)] = d[8*i +: 8];
        end else begin
            chk("no_writes", wlog.size(), 0);
            chk("rdata", got_rd, exp_rd);
        end
    endtask

    initial begin
        int          first, second, g1, g2, nd;
        bit          p, we;
        logic [1:0]  sz;
        logic [31:0] a;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
        f_r0_req = 1'b0;
        f_r1_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_done", {r0_done, r1_done}, 2'b00);
        rst = 1'b0;

        xact(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
        xact(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        chk("t2_rdata", rdata, 32'hDEADBEEF);

        // Make port 0 the last owner, then contend with byte stores.
        xact(1'b0, 1'b0, 2'b00, 32'h10, 32'h0);
        @(posedge clk); #1;
        wlog.delete();
        set_req(1'b0, 1'b1, 1'b1, 2'b00, 32'h30, 32'h5A);
        set_req(1'b1, 1'b1, 1'b1, 2'b00, 32'h31, 32'hC3);
        first = -1; second = -1; g1 = -1; g2 = -1; nd = 0;
        for (int j = 0; j < 30 && nd < 2; j++) begin
            @(posedge clk); #1;
            if (r0_done || r1_done) begin
                if (nd == 0) begin first = r1_done; g1 = grant; end
                else begin second = r1_done; g2 = grant; end
                nd++;
                if (r0_done) set_req(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
                if (r1_done) set_req(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
            end
        end
        set_req(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
        chk("rr_ndone", nd, 2);
        chk("rr_first", first, 1);
        chk("rr_grant1", g1, 1);
        chk("rr_second", second, 0);
        chk("rr_grant2", g2, 0);
        chk("rr_mem30", rd_phys(32'h30), 8'h5A);
        chk("rr_mem31", rd_phys(32'h31), 8'hC3);
        shadow[32'h30] = 8'h5A;
        shadow[32'h31] = 8'hC3;

        xact(1'b0, 1'b0, 2'b00, 32'h13, 32'h0);
        chk("t4_rdata", rdata, 32'h000000DE);
        xact(1'b0, 1'b1, 2'b01, 32'h7, 32'h0000A5B6);
        chk("t4_mem07", rd_phys(32'h7), 8'hB6);
        chk("t4_mem08", rd_phys(32'h8), 8'hA5);
        xact(1'b1, 1'b1, 2'b10, 32'hFFFFFFFE, 32'h01020304);
        xact(1'b0, 1'b0, 2'b11, 32'hFFFFFFFE, 32'h0);

        for (int it = 0; it < 40; it++) begin
            p  = 1'($urandom);
            we = 1'($urandom);
            sz = 2'($urandom);
            a  = (it % 8 == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                               : 32'($urandom_range(0, 40));
            xact(p, we, sz, a, $urandom);
        end

        // Reset during the third byte of a word store.
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 2'b10, 32'h20, 32'h11223344);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_en", mem_en, 1'b1);
        chk("rst_mid_addr", mem_addr, 32'h22);
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
        @(posedge clk); #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_mem_en", mem_en, 1'b0);
        rst = 1'b0;
        shadow[32'h20] = 8'h44;
        shadow[32'h21] = 8'h33;
        shadow[32'h22] = 8'h22;
        nd = 0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (r0_done || r1_done) nd++;
        end
        chk("rst_mid_nodone", nd, 0);
        xact(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);

        // Fixed-priority instance: port 0 must win a contended start.
        @(posedge clk); #1;
        f_r0_req = 1'b1;
        f_r1_req = 1'b1;
        first = -1; second = -1; g1 = -1; nd = 0;
        for (int j = 0; j < 30 && nd < 2; j++) begin
            @(posedge clk); #1;
            if (f_r0_done || f_r1_done) begin
                if (nd == 0) begin first = f_r1_done; g1 = f_grant; end
                else second = f_r1_done;
                nd++;
                if (f_r0_done) f_r0_req = 1'b0;
                if (f_r1_done) f_r1_req = 1'b0;
            end
        end
        f_r0_req = 1'b0;
        f_r1_req = 1'b0;
        chk("fp_ndone", nd, 2);
        chk("fp_first", first, 0);
        chk("fp_grant1", g1, 0);
        chk("fp_second", second, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
